// File: rtl/tpu_pkg.sv
// Shared types and constants for the instruction sequencer.
package tpu_pkg;

   localparam int unsigned INSTR_W    = 24;
   localparam int unsigned PROG_DEPTH = 16;

   localparam logic [INSTR_W-1:0] NOP_INSTR = 24'h000000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } seq_state_t;

endpackage : tpu_pkg

// File: rtl/instr_mem.sv
// Program store: register file with one synchronous write and one combinational read port.
module instr_mem #(
   parameter int unsigned DATA_W = 24,
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Write port; contents are intentionally not reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule : instr_mem

// File: rtl/instr_seq.sv
// Instruction sequencer: buffers a host-loaded program and replays it to the nn control unit.
module instr_seq
   import tpu_pkg::*;
#(
   parameter int unsigned INSTR_W    = tpu_pkg::INSTR_W,
   parameter int unsigned PROG_DEPTH = tpu_pkg::PROG_DEPTH
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [INSTR_W-1:0]                   host_instr_in,
   input  logic                                 host_instr_valid_in,
   output logic                                 host_instr_ready_out,
   input  logic                                 seq_clear_in,
   input  logic                                 seq_start_in,
   input  logic [7:0]                           seq_loop_count_in,
   output logic [INSTR_W-1:0]                   instruction_out,
   output logic                                 seq_busy_out,
   output logic                                 seq_done_out,
   output logic [$clog2(PROG_DEPTH+1)-1:0]      seq_count_out
);

   localparam int unsigned CNT_W = $clog2(PROG_DEPTH + 1);
   localparam int unsigned PTR_W = $clog2(PROG_DEPTH);

   seq_state_t         state_q, state_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [7:0]         loops_q, loops_d;
   logic [INSTR_W-1:0] instr_d;
   logic               busy_d;
   logic               done_d;

   logic               wr_en_c;
   logic [PTR_W-1:0]   rd_addr_c;
   logic [INSTR_W-1:0] rd_data_c;
   logic               last_c;

   assign host_instr_ready_out = (state_q == IDLE) && (count_q < CNT_W'(PROG_DEPTH));
   assign seq_count_out        = count_q;

   instr_mem #(
      .DATA_W (INSTR_W),
      .DEPTH  (PROG_DEPTH),
      .ADDR_W (PTR_W)
   ) u_instr_mem (
      .clk     (clk),
      .wr_en   (wr_en_c),
      .wr_addr (wr_ptr_q),
      .wr_data (host_instr_in),
      .rd_addr (rd_addr_c),
      .rd_data (rd_data_c)
   );

   // Next-state, pointer/counter updates and next registered outputs.
   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      loops_d   = loops_q;
      instr_d   = INSTR_W'(NOP_INSTR);
      busy_d    = 1'b0;
      done_d    = 1'b0;
      wr_en_c   = 1'b0;
      rd_addr_c = '0;
      last_c    = (CNT_W'(rd_ptr_q) == (count_q - CNT_W'(1)));

      unique case (state_q)
         IDLE: begin
            // Clear wins over any same-cycle write or start.
            if (seq_clear_in) begin
               count_d  = '0;
               wr_ptr_d = '0;
            end else begin
               wr_en_c = host_instr_valid_in && host_instr_ready_out;
               if (wr_en_c) begin
                  count_d  = count_q + CNT_W'(1);
                  wr_ptr_d = wr_ptr_q + PTR_W'(1);
               end
               if (seq_start_in && (count_d != '0)) begin
                  state_d  = RUN;
                  rd_ptr_d = '0;
                  loops_d  = (seq_loop_count_in == 8'd0) ? 8'd1 : seq_loop_count_in;
                  busy_d   = 1'b1;
                  // Entry 0 may be the word being written this very cycle.
                  instr_d  = (wr_en_c && (wr_ptr_q == '0)) ? host_instr_in : rd_data_c;
               end
            end
         end

         RUN: begin
            busy_d = 1'b1;
            if (last_c) begin
               if (loops_q > 8'd1) begin
                  rd_ptr_d = '0;
                  loops_d  = loops_q - 8'd1;
                  instr_d  = rd_data_c;
               end else begin
                  state_d = DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end
            end else begin
               rd_ptr_d  = rd_ptr_q + PTR_W'(1);
               rd_addr_c = rd_ptr_q + PTR_W'(1);
               instr_d   = rd_data_c;
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, pointers, counters and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= IDLE;
         count_q         <= '0;
         wr_ptr_q        <= '0;
         rd_ptr_q        <= '0;
         loops_q         <= 8'd0;
         instruction_out <= INSTR_W'(NOP_INSTR);
         seq_busy_out    <= 1'b0;
         seq_done_out    <= 1'b0;
      end else begin
         state_q         <= state_d;
         count_q         <= count_d;
         wr_ptr_q        <= wr_ptr_d;
         rd_ptr_q        <= rd_ptr_d;
         loops_q         <= loops_d;
         instruction_out <= instr_d;
         seq_busy_out    <= busy_d;
         seq_done_out    <= done_d;
      end
   end

endmodule : instr_seq

// File: tb/tb_instr_seq.sv
// Self-checking bench for instr_seq: per-cycle vector table plus multi-cycle corner sequences.
module tb_instr_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic [23:0] host_instr_in;
   logic        host_instr_valid_in;
   logic        host_instr_ready_out;
   logic        seq_clear_in;
   logic        seq_start_in;
   logic [7:0]  seq_loop_count_in;
   logic [23:0] instruction_out;
   logic        seq_busy_out;
   logic        seq_done_out;
   logic [4:0]  seq_count_out;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic        rst;
      logic        valid;
      logic [23:0] data;
      logic        clear;
      logic        start;
      logic [7:0]  loop;
      logic        e_ready;
      logic [23:0] e_instr;
      logic        e_busy;
      logic        e_done;
      logic [4:0]  e_cnt;
   } vec_t;

   vec_t vecs[$];

   instr_seq dut (
      .clk                  (clk),
      .rst                  (rst),
      .host_instr_in        (host_instr_in),
      .host_instr_valid_in  (host_instr_valid_in),
      .host_instr_ready_out (host_instr_ready_out),
      .seq_clear_in         (seq_clear_in),
      .seq_start_in         (seq_start_in),
      .seq_loop_count_in    (seq_loop_count_in),
      .instruction_out      (instruction_out),
      .seq_busy_out         (seq_busy_out),
      .seq_done_out         (seq_done_out),
      .seq_count_out        (seq_count_out)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic r, input logic v, input logic [23:0] d,
                               input logic c, input logic s, input logic [7:0] l,
                               input logic er, input logic [23:0] ei, input logic eb,
                               input logic ed, input logic [4:0] ec);
      vec_t t;
      t.rst = r; t.valid = v; t.data = d; t.clear = c; t.start = s; t.loop = l;
      t.e_ready = er; t.e_instr = ei; t.e_busy = eb; t.e_done = ed; t.e_cnt = ec;
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic v, input logic [23:0] d,
                        input logic c, input logic s, input logic [7:0] l);
      rst = r; host_instr_valid_in = v; host_instr_in = d;
      seq_clear_in = c; seq_start_in = s; seq_loop_count_in = l;
   endtask

   // Advance one clock and sample just after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input string tag, input logic er, input logic [23:0] ei,
                          input logic eb, input logic ed, input logic [4:0] ec);
      chk({tag, " ready"}, 32'(host_instr_ready_out), 32'(er));
      chk({tag, " instr"}, 32'(instruction_out), 32'(ei));
      chk({tag, " busy"},  32'(seq_busy_out), 32'(eb));
      chk({tag, " done"},  32'(seq_done_out), 32'(ed));
      chk({tag, " count"}, 32'(seq_count_out), 32'(ec));
   endtask

   initial begin
      logic saw_bad;

      //              rst v data       clr st lp     rdy instr      bsy dn cnt
      vecs.push_back(mk(1, 0, 24'h0,      0, 0, 8'd0,  1, 24'h0,      0, 0, 5'd0)); // reset
      vecs.push_back(mk(0, 1, 24'h11,     0, 0, 8'd0,  1, 24'h0,      0, 0, 5'd1));
      vecs.push_back(mk(0, 1, 24'h22,     0, 0, 8'd0,  1, 24'h0,      0, 0, 5'd2));
      vecs.push_back(mk(0, 1, 24'h33,     0, 0, 8'd0,  1, 24'h0,      0, 0, 5'd3));
      vecs.push_back(mk(0, 0, 24'h0,      0, 1, 8'd1,  0, 24'h11,     1, 0, 5'd3)); // start
      vecs.push_back(mk(0, 0, 24'h0,      0, 1, 8'd5,  0, 24'h22,     1, 0, 5'd3)); // start in RUN
      vecs.push_back(mk(0, 0, 24'h0,      0, 0, 8'd0,  0, 24'h33,     1, 0, 5'd3));
      vecs.push_back(mk(0, 0, 24'h0,      0, 0, 8'd0,  0, 24'h0,      0, 1, 5'd3)); // done
      vecs.push_back(mk(0, 0, 24'h0,      0, 1, 8'd1,  1, 24'h0,      0, 0, 5'd3)); // start in DONE
      vecs.push_back(mk(0, 0, 24'h0,      0, 1, 8'd0,  0, 24'h11,     1, 0, 5'd3)); // replay, loop 0
      vecs.push_back(mk(0, 1, 24'h99,     0, 0, 8'd0,  0, 24'h22,     1, 0, 5'd3)); // write in RUN
      vecs.push_back(mk(0, 0, 24'h0,      0, 0, 8'd0,  0, 24'h33,     1, 0, 5'd3));
      vecs.push_back(mk(0, 1, 24'h99,     1, 0, 8'd0,  0, 24'h0,      0, 1, 5'd3)); // clear in RUN
      vecs.push_back(mk(0, 1, 24'h77,     0, 0, 8'd0,  1, 24'h0,      0, 0, 5'd3)); // write in DONE
      vecs.push_back(mk(0, 0, 24'h0,      1, 0, 8'd0,  1, 24'h0,      0, 0, 5'd0)); // clear
      vecs.push_back(mk(0, 0, 24'h0,      0, 1, 8'd1,  1, 24'h0,      0, 0, 5'd0)); // start, empty
      vecs.push_back(mk(0, 0, 24'h0,      0, 0, 8'd0,  1, 24'h0,      0, 0, 5'd0));
      vecs.push_back(mk(0, 1, 24'hAA,     0, 1, 8'd1,  0, 24'hAA,     1, 0, 5'd1)); // write+start, empty
      vecs.push_back(mk(0, 0, 24'h0,      0, 0, 8'd0,  0, 24'h0,      0, 1, 5'd1));
      vecs.push_back(mk(0, 0, 24'h0,      0, 0, 8'd0,  1, 24'h0,      0, 0, 5'd1));
      vecs.push_back(mk(0, 1, 24'hBB,     0, 1, 8'd3,  0, 24'hAA,     1, 0, 5'd2)); // write+start, cnt 1
      vecs.push_back(mk(0, 0, 24'h0,      0, 0, 8'd0,  0, 24'hBB,     1, 0, 5'd2));
      vecs.push_back(mk(0, 0, 24'h0,      0, 0, 8'd0,  0, 24'hAA,     1, 0, 5'd2));
      vecs.push_back(mk(0, 0, 24'h0,      0, 0, 8'd0,  0, 24'hBB,     1, 0, 5'd2));
      vecs.push_back(mk(0, 0, 24'h0,      0, 0, 8'd0,  0, 24'hAA,     1, 0, 5'd2));
      vecs.push_back(mk(0, 0, 24'h0,      0, 0, 8'd0,  0, 24'hBB,     1, 0, 5'd2));
      vecs.push_back(mk(0, 0, 24'h0,      0, 0, 8'd0,  0, 24'h0,      0, 1, 5'd2));
      vecs.push_back(mk(0, 0, 24'h0,      0, 0, 8'd0,  1, 24'h0,      0, 0, 5'd2));
      vecs.push_back(mk(0, 0, 24'h0,      1, 1, 8'd1,  1, 24'h0,      0, 0, 5'd0)); // clear+start
      vecs.push_back(mk(0, 0, 24'h0,      0, 0, 8'd0,  1, 24'h0,      0, 0, 5'd0));
      vecs.push_back(mk(0, 1, 24'h55,     1, 0, 8'd0,  1, 24'h0,      0, 0, 5'd0)); // clear+write
      vecs.push_back(mk(0, 1, 24'hA1,     0, 0, 8'd0,  1, 24'h0,      0, 0, 5'd1));
      vecs.push_back(mk(0, 1, 24'hB2,     0, 0, 8'd0,  1, 24'h0,      0, 0, 5'd2));
      vecs.push_back(mk(0, 0, 24'h0,      0, 1, 8'd0,  0, 24'hA1,     1, 0, 5'd2)); // loop 0
      vecs.push_back(mk(0, 0, 24'h0,      0, 0, 8'd0,  0, 24'hB2,     1, 0, 5'd2));
      vecs.push_back(mk(0, 0, 24'h0,      0, 0, 8'd0,  0, 24'h0,      0, 1, 5'd2));
      vecs.push_back(mk(0, 0, 24'h0,      0, 0, 8'd0,  1, 24'h0,      0, 0, 5'd2));

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].rst, vecs[i].valid, vecs[i].data, vecs[i].clear, vecs[i].start, vecs[i].loop);
         tick();
         chk_all($sformatf("vec%0d", i), vecs[i].e_ready, vecs[i].e_instr,
                 vecs[i].e_busy, vecs[i].e_done, vecs[i].e_cnt);
      end

      // Full buffer: 17 writes, the last one dropped, then exactly 16 words played.
      drive(0, 0, 24'h0, 1, 0, 8'd0);
      tick();
      for (int i = 0; i < 17; i++) begin
         chk($sformatf("full ready before w%0d", i), 32'(host_instr_ready_out), 32'(i < 16));
         drive(0, 1, 24'h500 + 24'(i), 0, 0, 8'd0);
         tick();
      end
      drive(0, 0, 24'h0, 0, 0, 8'd0);
      chk("full count", 32'(seq_count_out), 32'd16);
      chk("full ready", 32'(host_instr_ready_out), 32'd0);
      drive(0, 0, 24'h0, 0, 1, 8'd1);
      for (int k = 0; k < 16; k++) begin
         tick();
         drive(0, 0, 24'h0, 0, 0, 8'd0);
         chk($sformatf("full play%0d", k), 32'(instruction_out), 32'h500 + 32'(k));
         chk($sformatf("full busy%0d", k), 32'(seq_busy_out), 32'd1);
      end
      tick();
      chk_all("full end", 1'b0, 24'h0, 1'b0, 1'b1, 5'd16);
      tick();
      chk_all("full idle", 1'b0, 24'h0, 1'b0, 1'b0, 5'd16);

      // Reset mid-run: 8 words, loop 2, reset while the 5th word is on the output.
      drive(0, 0, 24'h0, 1, 0, 8'd0);
      tick();
      for (int i = 0; i < 8; i++) begin
         drive(0, 1, 24'h800 + 24'(i), 0, 0, 8'd0);
         tick();
      end
      drive(0, 0, 24'h0, 0, 1, 8'd2);
      for (int k = 0; k < 5; k++) begin
         tick();
         drive(0, 0, 24'h0, 0, 0, 8'd0);
         chk($sformatf("rst run%0d", k), 32'(instruction_out), 32'h800 + 32'(k));
      end
      drive(1, 0, 24'h0, 0, 0, 8'd0);
      tick();
      drive(0, 0, 24'h0, 0, 0, 8'd0);
      chk_all("after rst", 1'b1, 24'h0, 1'b0, 1'b0, 5'd0);
      saw_bad = 1'b0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (seq_done_out || seq_busy_out || (instruction_out != 24'h0)) saw_bad = 1'b1;
      end
      chk("no done after rst", 32'(saw_bad), 32'd0);
      drive(0, 0, 24'h0, 0, 1, 8'd1);
      tick();
      drive(0, 0, 24'h0, 0, 0, 8'd0);
      chk_all("restart after rst", 1'b1, 24'h0, 1'b0, 1'b0, 5'd0);
      tick();
      chk_all("restart after rst+1", 1'b1, 24'h0, 1'b0, 1'b0, 5'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_instr_seq

// File: doc/instr_seq.md
INSTR_SEQ -- requirements
Module: instr_seq

Interface
REQ-001 The block SHALL have these parameters: INSTR_W, default 24, instruction width; PROG_DEPTH, default 16, program buffer entries.
REQ-002 The block SHALL have these ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  reset, synchronous, active-high
host_instr_in  input  24  instruction word from host
host_instr_valid_in  input  1  host word valid
host_instr_ready_out  output  1  buffer can accept a word
seq_clear_in  input  1  empty the program buffer
seq_start_in  input  1  begin program playback
seq_loop_count_in  input  8  program repetitions; 0 treated as 1
instruction_out  output  24  registered instruction to the nn control unit
seq_busy_out  output  1  playback in progress
seq_done_out  output  1  one-cycle completion pulse
seq_count_out  output  5  number of stored instructions, 0..16

Function
REQ-003 The block SHALL implement the FSM states IDLE, RUN and DONE.
REQ-004 The block SHALL drive host_instr_ready_out = (state==IDLE) && (count<PROG_DEPTH), as pure state decode.
REQ-005 A write SHALL occur when valid&&ready; it stores host_instr_in at wr_ptr, then increments wr_ptr and count.
REQ-006 A write while ready=0 SHALL be dropped with no state change.
REQ-007 In IDLE, seq_clear_in SHALL zero count and wr_ptr; clear beats a same-cycle write and a same-cycle start.
REQ-008 Start SHALL be acted on only when: state is IDLE, clear=0, and post-write count>0.
  - A start with count==0 SHALL be ignored.
  - A start outside IDLE SHALL be ignored.
REQ-009 A same-cycle write and start in IDLE SHALL both be honoured, and the new word SHALL be part of the program.
REQ-010 On an accepted start, the FSM SHALL enter RUN, set rd_ptr=0, and latch loops = max(seq_loop_count_in,1).
REQ-011 In RUN, each cycle SHALL register instruction_out <= mem[rd_ptr].
  - Entry 0 SHALL appear on instruction_out in the cycle after start is sampled (latency 1).
  - No bubbles SHALL occur between entries or between loops.
REQ-012 At rd_ptr==count-1 during RUN:
  - If loops>1, rd_ptr SHALL wrap to 0 and loops SHALL decrement.
  - Otherwise the FSM SHALL go to DONE.
REQ-013 Total issued words SHALL equal count*loops.
REQ-014 In IDLE and DONE, instruction_out SHALL be 24'h000000 (NOP), registered.
REQ-015 The block SHALL drive seq_busy_out=1 exactly in the cycles instruction_out carries a program word.
REQ-016 DONE SHALL last one cycle, assert seq_done_out=1 in that cycle, then return to IDLE.
REQ-017 The program and count SHALL be retained after DONE, so a re-start replays it without reload.
REQ-018 Writes and clear SHALL be ignored during RUN and DONE.
REQ-019 seq_count_out SHALL equal count at all times and SHALL never exceed 16.

Reset
REQ-020 On rst the block SHALL set: state=IDLE, count=0, wr_ptr=0, rd_ptr=0, loops=0.
REQ-021 On rst the outputs SHALL be: instruction_out=0, seq_busy_out=0, seq_done_out=0, host_instr_ready_out=1.
REQ-022 Program memory contents SHALL NOT be reset; entries are don't-care while count=0.
REQ-023 rst asserted mid-RUN SHALL drive instruction_out=0 from the next edge, and no seq_done_out pulse SHALL follow.

Structure
REQ-024 A shared package tpu_pkg SHALL hold INSTR_W, PROG_DEPTH, NOP_INSTR (24'h0) and the seq_state_t enum {IDLE,RUN,DONE}.
REQ-025 The program store SHALL be a separate sub-module instr_mem with the following properties:
  - 16x24 register file.
  - One synchronous write port.
  - One combinational read port.
REQ-026 The FSM, pointers and counters SHALL live in instr_seq.

Verification
REQ-027 Basic playback: write 24'h000011, 24'h000022, 24'h000033; start with loop=1.
  - instruction_out SHALL be 11,22,33 on cycles +1..+3.
  - busy SHALL be high on the same cycles.
  - done SHALL pulse on cycle +4.
  - instruction_out SHALL be 0 after.
REQ-028 Looping: 2-word program {A,B}, loop=3 -> instruction_out SHALL be A,B,A,B,A,B back-to-back, then one done pulse; loop=0 -> A,B once.
REQ-029 Full buffer: 17 valid writes in IDLE.
  - Ready SHALL drop after the 16th.
  - The 17th word SHALL be dropped.
  - seq_count_out SHALL read 16.
  - Playback SHALL issue exactly 16 words.
REQ-030 Simultaneous events:
  - Start with count==0 -> no busy and no done.
  - Write+start in the same cycle with count=1 -> 2 words issued.
  - Clear+start -> count=0 and no playback.
  - Write during RUN -> ignored and count unchanged.
REQ-031 Reset mid-run: 8-word program, loop=2, rst on the 5th issued cycle.
  - instruction_out SHALL be 0 from the next cycle.
  - busy SHALL be 0 from the next cycle.
  - seq_count_out SHALL be 0.
  - No done pulse SHALL occur.
  - A re-start SHALL be ignored until new writes.
